// File: rtl/div16_pkg.sv
// div16_pkg: shared state encodings and iteration constants for the sequential divider
package div16_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int ITERATIONS = 16;
  localparam int CNT_W = 4;
endpackage

// File: rtl/div16_seq_sub16.sv
// Sub16: 16-bit subtractor, carry high when a >= b (no borrow)
module Sub16 (
  input  logic [15:0] a,
  input  logic [15:0] b,
  output logic [15:0] o,
  output logic        carry
);
  logic [16:0] diff;
  assign diff = {1'b0, a} - {1'b0, b};
  assign o = diff[15:0];
  assign carry = ~diff[16];
endmodule

// File: rtl/div16_seq.sv
// div16_seq: 16-bit unsigned restoring divider, one quotient bit per clock
module div16_seq
  import div16_pkg::*;
#(
  parameter logic [15:0] DBZ_QUOTIENT = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] dividend,
  input  logic [15:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [15:0] quotient,
  output logic [15:0] remainder,
  output logic        dbz
);
  state_t state;
  logic [15:0] q, r, d, o, r_next, q_next;
  logic [CNT_W-1:0] cnt;
  logic [16:0] s;
  logic carry, take;
  assign s = {r, q[15]};
  Sub16 u_sub (.a(s[15:0]), .b(d), .o(o), .carry(carry));
  // s[16] set means the shifted remainder already exceeds any 16-bit divisor
  assign take = s[16] | carry;
  assign r_next = take ? o : s[15:0];
  assign q_next = {q[14:0], take};
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      quotient <= '0;
      remainder <= '0;
      dbz <= 1'b0;
      q <= '0;
      r <= '0;
      d <= '0;
      cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && divisor != '0) begin
            q <= dividend;
            r <= '0;
            d <= divisor;
            cnt <= '0;
            busy <= 1'b1;
            state <= RUN;
          end else if (start) begin
            quotient <= DBZ_QUOTIENT;
            remainder <= dividend;
            dbz <= 1'b1;
            busy <= 1'b1;
            done <= 1'b1;
            state <= DONE;
          end
        end
        RUN: begin
          r <= r_next;
          q <= q_next;
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(ITERATIONS - 1)) begin
            quotient <= q_next;
            remainder <= r_next;
            dbz <= 1'b0;
            done <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_div16_seq.sv
// tb_div16_seq: directed and swept checks of the sequential divider
module tb_div16_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start = 1'b0;
  logic [15:0] dividend = '0, divisor = '0;
  logic busy, done, dbz;
  logic [15:0] quotient, remainder;
  int n_cmp = 0, n_err = 0;

  div16_seq #(.DBZ_QUOTIENT(16'hFFFF)) dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder), .dbz(dbz)
  );

  always #5 clk = ~clk;

  // launch one division and follow it to its done pulse (bounded at 40 cycles)
  task automatic do_div(input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] qo, output logic [15:0] ro, output logic zo,
                        output int lat, output int busy_n);
    @(negedge clk);
    dividend = a;
    divisor = b;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    lat = 0;
    busy_n = 0;
    while (lat < 40) begin
      @(negedge clk);
      lat++;
      if (busy) busy_n++;
      if (done) break;
    end
    qo = quotient;
    ro = remainder;
    zo = dbz;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_err++; $display("FAIL reset_done: got %b want 0", done); end
    n_cmp++; if (quotient !== 16'h0 || remainder !== 16'h0) begin n_err++; $display("FAIL reset_q_r: got %h/%h want 0000/0000", quotient, remainder); end
    n_cmp++; if (dbz !== 1'b0) begin n_err++; $display("FAIL reset_dbz: got %b want 0", dbz); end
    rst = 1'b0;
  endtask

  task automatic test_basic();
    logic [15:0] qo, ro; logic zo; int lat, bn;
    do_div(16'd100, 16'd7, qo, ro, zo, lat, bn);
    n_cmp++; if (lat !== 17) begin n_err++; $display("FAIL basic_latency: got %0d want 17", lat); end
    n_cmp++; if (bn !== 17) begin n_err++; $display("FAIL basic_busy_cycles: got %0d want 17", bn); end
    n_cmp++; if (qo !== 16'd14 || ro !== 16'd2 || zo !== 1'b0) begin n_err++; $display("FAIL basic_100_7: got q=%0d r=%0d z=%b want q=14 r=2 z=0", qo, ro, zo); end
    @(negedge clk);
    n_cmp++; if (done !== 1'b0 || busy !== 1'b0) begin n_err++; $display("FAIL basic_after_done: got done=%b busy=%b want 0 0", done, busy); end
  endtask

  task automatic test_s16();
    logic [15:0] qo, ro; logic zo; int lat, bn;
    do_div(16'hFFFF, 16'h8001, qo, ro, zo, lat, bn);
    n_cmp++; if (qo !== 16'd1 || ro !== 16'h7FFE) begin n_err++; $display("FAIL s16_ffff_8001: got q=%h r=%h want q=0001 r=7ffe", qo, ro); end
    do_div(16'h8000, 16'hFFFF, qo, ro, zo, lat, bn);
    n_cmp++; if (qo !== 16'd0 || ro !== 16'h8000) begin n_err++; $display("FAIL s16_8000_ffff: got q=%h r=%h want q=0000 r=8000", qo, ro); end
  endtask

  task automatic test_dbz();
    logic [15:0] qo, ro; logic zo; int lat, bn;
    do_div(16'h1234, 16'h0000, qo, ro, zo, lat, bn);
    n_cmp++; if (lat !== 1) begin n_err++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    n_cmp++; if (qo !== 16'hFFFF || ro !== 16'h1234 || zo !== 1'b1) begin n_err++; $display("FAIL dbz_result: got q=%h r=%h z=%b want q=ffff r=1234 z=1", qo, ro, zo); end
    do_div(16'd7, 16'd3, qo, ro, zo, lat, bn);
    n_cmp++; if (qo !== 16'd2 || ro !== 16'd1 || zo !== 1'b0) begin n_err++; $display("FAIL dbz_cleared: got q=%0d r=%0d z=%b want q=2 r=1 z=0", qo, ro, zo); end
    repeat (5) @(negedge clk);
    n_cmp++; if (quotient !== 16'd2 || remainder !== 16'd1) begin n_err++; $display("FAIL hold_outputs: got q=%0d r=%0d want q=2 r=1", quotient, remainder); end
  endtask

  task automatic test_start_held();
    int n_done = 0;
    int first = 0, second = 0;
    logic [15:0] q1 = '0, r1 = '0, q2 = '0, r2 = '0;
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 16'd10;
    start = 1'b1;
    @(posedge clk);
    #1 dividend = 16'h5555;
    divisor = 16'd3;
    for (int i = 1; i <= 36; i++) begin
      @(negedge clk);
      if (done) begin
        n_done++;
        if (n_done == 1) begin first = i; q1 = quotient; r1 = remainder; end
        else begin second = i; q2 = quotient; r2 = remainder; end
      end
      if (i == 36) start = 1'b0;
    end
    n_cmp++; if (n_done !== 2) begin n_err++; $display("FAIL held_done_count: got %0d want 2", n_done); end
    n_cmp++; if (first !== 17 || second !== 35) begin n_err++; $display("FAIL held_done_spacing: got %0d,%0d want 17,35", first, second); end
    n_cmp++; if (q1 !== 16'd100 || r1 !== 16'd0) begin n_err++; $display("FAIL held_first_result: got q=%0d r=%0d want q=100 r=0", q1, r1); end
    n_cmp++; if (q2 !== 16'd7281 || r2 !== 16'd2) begin n_err++; $display("FAIL held_second_result: got q=%0d r=%0d want q=7281 r=2", q2, r2); end
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL held_release_idle: got busy=%b want 0", busy); end
  endtask

  task automatic test_abort();
    logic [15:0] qo, ro; logic zo; int lat, bn; int pulses = 0;
    @(negedge clk);
    dividend = 16'd1000;
    divisor = 16'd7;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (8) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    n_cmp++; if ({busy, done, dbz} !== 3'b000 || quotient !== 16'h0 || remainder !== 16'h0) begin n_err++; $display("FAIL abort_outputs: got busy=%b done=%b dbz=%b q=%h r=%h want all 0", busy, done, dbz, quotient, remainder); end
    for (int i = 0; i < 20; i++) begin
      if (done) pulses++;
      @(negedge clk);
    end
    n_cmp++; if (pulses !== 0) begin n_err++; $display("FAIL abort_no_done: got %0d pulses want 0", pulses); end
    do_div(16'd65535, 16'd255, qo, ro, zo, lat, bn);
    n_cmp++; if (qo !== 16'd257 || ro !== 16'd0 || zo !== 1'b0) begin n_err++; $display("FAIL abort_recovery: got q=%0d r=%0d z=%b want q=257 r=0 z=0", qo, ro, zo); end
  endtask

  task automatic test_random();
    logic [15:0] a, b, qo, ro, eq, er; logic zo, ez; int lat, bn;
    for (int i = 0; i < 2000; i++) begin
      a = 16'($urandom);
      b = (i % 4 == 0) ? 16'($urandom_range(0, 15)) : 16'($urandom);
      if (b == 16'd0) begin eq = 16'hFFFF; er = a; ez = 1'b1; end
      else begin eq = a / b; er = a % b; ez = 1'b0; end
      do_div(a, b, qo, ro, zo, lat, bn);
      n_cmp++;
      if (qo !== eq || ro !== er || zo !== ez ||
          (b != 0 && ((32'(qo) * 32'(b) + 32'(ro)) != 32'(a) || ro >= b))) begin
        n_err++;
        $display("FAIL random_%0d: %0d/%0d got q=%0d r=%0d z=%b want q=%0d r=%0d z=%b", i, a, b, qo, ro, zo, eq, er, ez);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_s16();
    test_dbz();
    test_start_held();
    test_abort();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
